// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo: byte FIFO between the UART receiver and transmitter.
// Received bytes are queued in a circular buffer and handed to the
// transmitter through a registered output stage. When OPT_CRLF is set,
// an LF byte is sent after every CR.
module uart_echo_fifo #(
  parameter int LGFLEN   = 4,
  parameter bit OPT_CRLF = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_rx_stb,
  input  logic [7:0]        i_rx_data,
  output logic              o_tx_stb,
  output logic [7:0]        o_tx_data,
  input  logic              i_tx_busy,
  output logic [LGFLEN:0]   o_fill,
  output logic              o_empty,
  output logic              o_overflow
);

  localparam int DEPTH = 1 << LGFLEN;

  // State meanings:
  //   ST_IDLE - output register empty
  //   ST_SEND - output register holds a byte taken from the FIFO
  //   ST_LF   - output register holds an inserted LF
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_LF
  } state_e;

  logic [7:0]        mem_q [DEPTH];
  logic [LGFLEN-1:0] wr_ptr_q, rd_ptr_q;
  logic [LGFLEN:0]   fill_q, fill_d;
  state_e            state_q, state_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_stb_q, tx_stb_d;
  logic              empty_q;
  logic              overflow_q, overflow_d;

  logic              fifo_empty;
  logic              fifo_full;
  logic              accept;
  logic              pop;
  logic              push;
  logic [7:0]        head;

  // fill_q never exceeds DEPTH, so its top bit by itself means "full".
  assign fifo_empty = (fill_q == '0);
  assign fifo_full  = fill_q[LGFLEN];
  assign accept     = tx_stb_q && !i_tx_busy;
  assign head       = mem_q[rd_ptr_q];

  // Output sequencer: decides when to pop the FIFO and what to load into the
  // output register.
  // NOTE: every signal driven here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          tx_data_d = head;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (accept) begin
          if (OPT_CRLF && (tx_data_q == 8'h0D)) begin
            tx_data_d = 8'h0A;
            state_d   = ST_LF;
          end else if (!fifo_empty) begin
            pop       = 1'b1;
            tx_data_d = head;
          end else begin
            state_d   = ST_IDLE;
          end
        end
      end
      ST_LF: begin
        if (accept) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            tx_data_d = head;
            state_d   = ST_SEND;
          end else begin
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    tx_stb_d = (state_d != ST_IDLE);
  end

  // FIFO bookkeeping.
  // A full FIFO still accepts a byte when a pop happens in the same cycle.
  always_comb begin
    push       = i_rx_stb && (!fifo_full || pop);
    overflow_d = overflow_q || (i_rx_stb && !push);
    fill_d     = fill_q;
    case ({push, pop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
  end

  // Control and status registers; all clear asynchronously on reset.
  // NOTE: state elements use non-blocking assignments so every register
  // samples values from before the clock edge, whatever the block order.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      tx_data_q  <= 8'h00;
      tx_stb_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_stb_q   <= tx_stb_d;
      fill_q     <= fill_d;
      empty_q    <= (fill_d == '0);
      overflow_q <= overflow_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Buffer storage.
  // NOTE: the storage array is not reset; the pointers and the fill count
  // decide which entries are valid, so stale contents are never read.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_rx_data;
  end

  assign o_tx_stb   = tx_stb_q;
  assign o_tx_data  = tx_data_q;
  assign o_fill     = fill_q;
  assign o_empty    = empty_q;
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Testbench for uart_echo_fifo.
// A queue-based model of the byte stream is compared with the CRLF instance
// on every cycle. Both the CRLF instance and the no-CRLF instance also have
// their transmitted byte logs checked against hand-written lists.
module tb_uart_echo_fifo;

  localparam int LGFLEN = 4;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              i_reset;
  logic              rx_stb;
  logic [7:0]        rx_data;
  logic              busy;

  logic              o_tx_stb,    o_tx_stb_nc;
  logic [7:0]        o_tx_data,   o_tx_data_nc;
  logic [LGFLEN:0]   o_fill,      o_fill_nc;
  logic              o_empty,     o_empty_nc;
  logic              o_overflow,  o_overflow_nc;

  uart_echo_fifo #(.LGFLEN(LGFLEN), .OPT_CRLF(1'b1)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_rx_stb(rx_stb), .i_rx_data(rx_data),
    .o_tx_stb(o_tx_stb), .o_tx_data(o_tx_data), .i_tx_busy(busy),
    .o_fill(o_fill), .o_empty(o_empty), .o_overflow(o_overflow)
  );

  uart_echo_fifo #(.LGFLEN(LGFLEN), .OPT_CRLF(1'b0)) dut_nc (
    .i_clk(clk), .i_reset(i_reset), .i_rx_stb(rx_stb), .i_rx_data(rx_data),
    .o_tx_stb(o_tx_stb_nc), .o_tx_data(o_tx_data_nc), .i_tx_busy(busy),
    .o_fill(o_fill_nc), .o_empty(o_empty_nc), .o_overflow(o_overflow_nc)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: bytes waiting in the FIFO, plus one output slot.
  logic [7:0] mq[$];
  bit         m_valid;
  logic [7:0] m_data;
  bit         m_ovf;
  bit         m_acc;

  // Model update: first handle the transmitter side, then store the
  // incoming byte if there is room after any pop.
  always @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      mq.delete();
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_ovf   = 1'b0;
    end else begin
      m_acc = m_valid && !busy;
      if (m_acc && m_data == 8'h0D) begin
        m_data = 8'h0A;
      end else if ((!m_valid || m_acc) && mq.size() > 0) begin
        m_data  = mq.pop_front();
        m_valid = 1'b1;
      end else if (m_acc) begin
        m_valid = 1'b0;
      end
      if (rx_stb) begin
        if (mq.size() < DEPTH) mq.push_back(rx_data);
        else m_ovf = 1'b1;
      end
    end
  end

  logic [7:0] txlog[$];
  logic [7:0] txlog_nc[$];
  logic       prev_stb  = 1'b0;
  logic       prev_busy = 1'b0;
  logic [7:0] prev_data = 8'h00;

  // Per-cycle comparison against the model, a handshake-hold check, and
  // logging of every byte the transmitter accepts.
  always @(negedge clk) begin
    if (i_reset) begin
      prev_stb = 1'b0;
    end else begin
      check("tx_stb",   o_tx_stb,   m_valid);
      check("tx_data",  o_tx_data,  m_data);
      check("fill",     o_fill,     mq.size());
      check("empty",    o_empty,    mq.size() == 0);
      check("overflow", o_overflow, m_ovf);
      if (prev_stb && prev_busy) begin
        check("hold_stb",  o_tx_stb,  1);
        check("hold_data", o_tx_data, prev_data);
      end
      if (o_tx_stb && !busy)    txlog.push_back(o_tx_data);
      if (o_tx_stb_nc && !busy) txlog_nc.push_back(o_tx_data_nc);
      prev_stb  = o_tx_stb;
      prev_busy = busy;
      prev_data = o_tx_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_stb  = 1'b1;
    rx_data = b;
    tick();
    rx_stb  = 1'b0;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    txlog.delete();
    txlog_nc.delete();
    tick();
    tick();
    i_reset = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    busy = 1'b0;
    n = 0;
    while (!(o_empty && !o_tx_stb && o_empty_nc && !o_tx_stb_nc) && n < budget) begin
      tick();
      n++;
    end
    check({name, "_drained"}, o_empty && !o_tx_stb && o_empty_nc && !o_tx_stb_nc, 1);
  endtask

  task automatic compare_log(input string name, input logic [7:0] got[$], input logic [7:0] exp[$]);
    check({name, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s_byte%0d", name, i), got[i], exp[i]);
  endtask

  logic [7:0] exp_q[$];
  logic [7:0] exp_nc[$];
  logic [7:0] sent[$];
  bit         done;
  int         waitn;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b1;
    rx_stb  = 1'b0;
    rx_data = 8'h00;
    busy    = 1'b0;
    tick();
    tick();
    check("rst_tx_stb",   o_tx_stb,   0);
    check("rst_tx_data",  o_tx_data,  8'h00);
    check("rst_fill",     o_fill,     0);
    check("rst_empty",    o_empty,    1);
    check("rst_overflow", o_overflow, 0);
    i_reset = 1'b0;

    // 1. Single byte: fill rises first, then the strobe, for one cycle.
    tick();
    rx_stb  = 1'b1;
    rx_data = 8'h41;
    @(posedge clk);
    #1 rx_stb = 1'b0;
    @(negedge clk);
    check("t1_fill_after_k",  o_fill,   1);
    check("t1_stb_after_k",   o_tx_stb, 0);
    @(negedge clk);
    check("t1_stb_after_k1",  o_tx_stb,  1);
    check("t1_data_after_k1", o_tx_data, 8'h41);
    @(negedge clk);
    check("t1_stb_after_k2",  o_tx_stb, 0);
    check("t1_fill_after_k2", o_fill,   0);
    check("t1_empty_after_k2", o_empty, 1);
    tick();
    exp_q = '{8'h41};
    compare_log("t1_log", txlog, exp_q);

    // 2. Overflow: 20 bytes while busy; 17 fit (16 in FIFO + output reg).
    do_reset();
    busy = 1'b1;
    for (int i = 0; i < 20; i++) send(8'(i));
    check("t2_fill_peak", o_fill,     16);
    check("t2_overflow",  o_overflow, 1);
    drain("t2", 200);
    exp_q  = {};
    exp_nc = {};
    for (int b = 0; b <= 16; b++) begin
      exp_q.push_back(8'(b));
      exp_nc.push_back(8'(b));
      if (b == 13) exp_q.push_back(8'h0A);
    end
    compare_log("t2_log_crlf", txlog, exp_q);
    compare_log("t2_log_nc",   txlog_nc, exp_nc);

    // 3. CR expansion.
    do_reset();
    send(8'h0D);
    send(8'h41);
    drain("t3", 50);
    exp_q  = '{8'h0D, 8'h0A, 8'h41};
    exp_nc = '{8'h0D, 8'h41};
    compare_log("t3_log_crlf", txlog, exp_q);
    compare_log("t3_log_nc",   txlog_nc, exp_nc);

    // 4. Write into a full FIFO in the same cycle as a pop.
    do_reset();
    busy = 1'b1;
    for (int i = 0; i < 17; i++) send(8'(8'h20 + i));
    check("t4_fill_full", o_fill,   16);
    check("t4_stb",       o_tx_stb, 1);
    busy    = 1'b0;
    rx_stb  = 1'b1;
    rx_data = 8'h55;
    tick();
    rx_stb  = 1'b0;
    check("t4_fill_kept",  o_fill,     16);
    check("t4_no_overflow", o_overflow, 0);
    drain("t4", 100);
    exp_q = {};
    for (int i = 0; i < 17; i++) exp_q.push_back(8'(8'h20 + i));
    exp_q.push_back(8'h55);
    compare_log("t4_log_crlf", txlog, exp_q);
    compare_log("t4_log_nc",   txlog_nc, exp_q);

    // 5. Random stream with random busy stalls of 1-50 cycles.
    do_reset();
    sent = {};
    for (int i = 0; i < 100; i++) sent.push_back(8'($urandom_range(0, 255)));
    sent[10] = 8'h0D;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          waitn = 0;
          while (o_fill >= 14 && waitn < 300) begin
            tick();
            waitn++;
          end
          if (waitn >= 300) check("t5_sender_timeout", waitn, 0);
          send(sent[i]);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          tick();
          if (o_tx_stb && !busy && $urandom_range(0, 1) == 1) begin
            busy = 1'b1;
            repeat ($urandom_range(1, 50)) tick();
            busy = 1'b0;
          end
        end
      end
    join
    drain("t5", 300);
    exp_q  = {};
    exp_nc = {};
    foreach (sent[i]) begin
      exp_q.push_back(sent[i]);
      exp_nc.push_back(sent[i]);
      if (sent[i] == 8'h0D) exp_q.push_back(8'h0A);
    end
    compare_log("t5_log_crlf", txlog, exp_q);
    compare_log("t5_log_nc",   txlog_nc, exp_nc);
    check("t5_no_overflow", o_overflow, 0);

    // 6. Reset while bytes are buffered and the strobe is up.
    do_reset();
    busy = 1'b1;
    for (int i = 0; i < 6; i++) send(8'(8'h60 + i));
    check("t6_fill_before", o_fill,   5);
    check("t6_stb_before",  o_tx_stb, 1);
    i_reset = 1'b1;
    #1;
    check("t6_rst_stb",      o_tx_stb,   0);
    check("t6_rst_data",     o_tx_data,  8'h00);
    check("t6_rst_fill",     o_fill,     0);
    check("t6_rst_empty",    o_empty,    1);
    check("t6_rst_overflow", o_overflow, 0);
    txlog.delete();
    txlog_nc.delete();
    tick();
    i_reset = 1'b0;
    busy    = 1'b0;
    send(8'h77);
    drain("t6", 50);
    exp_q = '{8'h77};
    compare_log("t6_log_crlf", txlog, exp_q);
    compare_log("t6_log_nc",   txlog_nc, exp_q);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_echo_fifo.md
# uart_echo_fifo

Buffered byte stage between the receiver (`rxuart`) and the transmitter (`txuart`) in the echo design. It captures every received byte into a small FIFO, holds it until the transmitter can accept it, and optionally expands CR into CR LF on the way out. This removes the byte loss that occurs when a received strobe arrives while the transmitter is still busy.

## Interface

**Parameters**
- `LGFLEN`, default 4: log2 of the FIFO depth. Depth = 2^LGFLEN entries of 8 bits.
- `OPT_CRLF`, default 1: when 1, insert 0x0A after every transmitted 0x0D.

**Ports**
- `i_clk`  in  1  system clock; all logic is on its rising edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_rx_stb`  in  1  one-cycle strobe from the receiver; a byte is valid.
- `i_rx_data`  in  8  received byte, valid with `i_rx_stb`.
- `o_tx_stb`  out  1  transmit request to the transmitter (its write input).
- `o_tx_data`  out  8  byte to transmit; stable while `o_tx_stb` is high.
- `i_tx_busy`  in  1  transmitter busy; a byte is accepted on a cycle where `o_tx_stb && !i_tx_busy`.
- `o_fill`  out  LGFLEN+1  number of bytes in the FIFO; excludes the output register.
- `o_empty`  out  1  high when `o_fill == 0`.
- `o_overflow`  out  1  sticky; set when a received byte is dropped.

## Operation

**Reset values.** While `i_reset` is high, all state clears asynchronously:
- `o_tx_stb` = 0, `o_tx_data` = 0x00
- `o_fill` = 0, `o_empty` = 1, `o_overflow` = 0
- read/write pointers = 0, state = IDLE

Asserting reset mid-operation discards the FIFO contents and any in-flight byte; `o_tx_stb` drops immediately.

**FIFO.**
- Circular buffer; the pointers are LGFLEN bits wide and wrap modulo the depth.
- A write occurs on `i_rx_stb` when the FIFO is not full, or when it is full and a pop occurs in the same cycle. In that case the write is accepted and `o_fill` is unchanged.
- `i_rx_stb` while full with no pop: the byte is dropped, `o_overflow` is set to 1 and stays 1 until reset, and the pointers and `o_fill` are unchanged.
- `o_fill` update per cycle: +1 on write only, −1 on pop only, unchanged on both or neither.

**Output state machine** (registered output; `accept = o_tx_stb && !i_tx_busy`).
- **IDLE** (`o_tx_stb` = 0):
  - If the FIFO is non-empty, pop the head into `o_tx_data` and go to SEND.
  - Otherwise stay in IDLE.
- **SEND** (`o_tx_stb` = 1):
  - No accept: hold `o_tx_data`.
  - On accept, if `OPT_CRLF` and `o_tx_data` == 0x0D: load 0x0A and go to LF. Do not pop.
  - On accept otherwise, if the FIFO is non-empty: pop the next byte and stay in SEND (back-to-back, no idle gap).
  - On accept otherwise, if the FIFO is empty: go to IDLE.
- **LF** (`o_tx_stb` = 1, `o_tx_data` = 0x0A):
  - No accept: hold.
  - On accept: pop and go to SEND if the FIFO is non-empty, else go to IDLE.

**Ordering and capacity.**
- Bytes leave in arrival order.
- Total buffering is 2^LGFLEN + 1 bytes: the FIFO plus the output register.
- An inserted 0x0A occupies no FIFO entry.

## Timing

- **Latency:** with the FIFO empty and state IDLE, `i_rx_stb` sampled at edge k gives `o_fill` = 1 after edge k, then `o_tx_stb` = 1 with the byte after edge k+1. Pop-to-output latency is 1 cycle.
- **Throughput:** one byte per cycle in and one per cycle out. A write and a pop in the same cycle are both honoured.
- **Handshake:** `o_tx_stb` never deasserts, and `o_tx_data` never changes, without an accept (except on reset).
- **Status outputs:** `o_empty` and `o_overflow` are registered and consistent with `o_fill` on the same cycle.

## Test plan

1. **Single byte.** Reset, then one `i_rx_stb` with 0x41 and `i_tx_busy` = 0.
   - `o_tx_stb` rises 2 edges after the strobe with `o_tx_data` = 0x41, stays high for exactly 1 cycle, then `o_fill` = 0 and `o_empty` = 1.
2. **Overflow** (LGFLEN = 4). `i_tx_busy` held at 1; 20 consecutive strobes carrying 0x00..0x13.
   - `o_fill` peaks at 16 and `o_overflow` = 1.
   - After releasing busy, output is exactly 0x00..0x10 in order; 0x11–0x13 are lost.
3. **CRLF expansion** (`OPT_CRLF` = 1). Send 0x0D, then 0x41.
   - Output is 0x0D, 0x0A, 0x41 with no extra bytes.
   - With `OPT_CRLF` = 0, output is 0x0D, 0x41.
4. **Simultaneous full write and pop.** Fill to 16 with busy = 1, then drop busy in the same cycle as a new strobe (0x55).
   - `o_fill` stays 16, `o_overflow` stays 0, and 0x55 is emitted last.
5. **Busy stall.** Raise `i_tx_busy` for a random 1–50 cycles while `o_tx_stb` = 1.
   - `o_tx_data` stays constant and no byte is duplicated or skipped across a 100-byte random stream.
6. **Reset mid-stream.** Assert `i_reset` while `o_fill` = 5 and `o_tx_stb` = 1.
   - All outputs reach their reset values immediately.
   - The next received byte is the first one transmitted.
